// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: frame field widths, FSM state codes and header packing shared with the slave side
package spi_frame_pkg;
  localparam int EXT_W = 3;
  localparam int REG_W = 3;
  localparam int DATA_W = 8;
  localparam int HDR_BITS = 8;
  localparam int GAP_BITS = 1;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_GAP = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;
  // header bits after the R/W bit, packed so shifting right emits ext[0] first
  typedef struct packed {
    logic [REG_W-1:0] rg;
    logic rsv;
    logic [EXT_W-1:0] ext;
  } hdr_t;
  function automatic hdr_t mk_hdr(input logic [EXT_W-1:0] e, input logic [REG_W-1:0] r);
    return '{rg: r, rsv: 1'b0, ext: e};
  endfunction
endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: 8-bit parallel-load shift register with selectable MSB/LSB-first direction
module spi_shift8 (
  input  logic       sclk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] din,
  input  logic       sh,
  input  logic       msb_first,
  input  logic       sin,
  output logic [7:0] q
);
  always_ff @(posedge sclk) begin
    if (rst) q <= '0;
    else if (ld) q <= din;
    else if (sh) q <= msb_first ? {q[6:0], sin} : {sin, q[7:1]};
  end
endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: builds slave-bank frames on cs/mosi and collects one miso byte per data slot
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int LEN_W = 3,
  parameter int IDLE_MIN = 1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [2:0]       cmd_ext,
  input  logic [2:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  input  logic [7:0]       wd_data,
  output logic             wd_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err_nack,
  output logic             err_udr,
  output logic             cs,
  output logic             mosi,
  input  logic             miso,
  input  logic             miso_oe
);
  localparam int IW = $clog2(IDLE_MIN + 1);
  localparam logic [IW-1:0] IMIN = IW'(IDLE_MIN);
  logic [2:0] state, cnt, rcnt;
  logic [LEN_W-1:0] left;
  logic [HDR_BITS-2:0] hdr;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [7:0] tx_q, rx_q, rx_nxt;
  logic wr, p1, p2, latch, take, rbit, tx_unused;
  always_comb begin
    latch = (state == ST_HDR && cnt == 3'(HDR_BITS - 2)) || state == ST_GAP;
    take = latch & wr & wd_valid;
    rbit = miso & miso_oe;
    rx_nxt = wr ? {rx_q[6:0], rbit} : {rbit, rx_q[7:1]};
    idle_nxt = idle_cnt == IMIN ? idle_cnt : idle_cnt + 1'b1;
  end
  assign tx_unused = ^tx_q[6:0];
  spi_shift8 u_tx (
    .sclk(sclk), .rst(rst), .ld(latch), .din(take ? wd_data : 8'h00),
    .sh(state == ST_DATA), .msb_first(1'b1), .sin(1'b0), .q(tx_q)
  );
  // miso lags the driving edge by two: p2 marks an edge that samples a data bit
  spi_shift8 u_rx (
    .sclk(sclk), .rst(rst), .ld(1'b0), .din(8'h00),
    .sh(p2), .msb_first(wr), .sin(rbit), .q(rx_q)
  );
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      rcnt <= '0;
      left <= '0;
      hdr <= '0;
      idle_cnt <= '0;
      wr <= 1'b0;
      p1 <= 1'b0;
      p2 <= 1'b0;
      cs <= 1'b0;
      mosi <= 1'b0;
      cmd_ready <= 1'b0;
      wd_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      done <= 1'b0;
      err_nack <= 1'b0;
      err_udr <= 1'b0;
    end else begin
      wd_ready <= take;
      rd_valid <= 1'b0;
      done <= 1'b0;
      p1 <= state == ST_DATA;
      p2 <= p1;
      err_udr <= err_udr | (latch & wr & ~wd_valid);
      if (p2) begin
        rcnt <= rcnt + 1'b1;
        err_nack <= err_nack | ~miso_oe;
        if (rcnt == 3'd7) begin
          rd_valid <= 1'b1;
          rd_data <= rx_nxt;
        end
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cs <= 1'b1;
            mosi <= cmd_wr;
            wr <= cmd_wr;
            hdr <= mk_hdr(cmd_ext, cmd_reg);
            left <= cmd_len;
            cnt <= '0;
            state <= ST_HDR;
            cmd_ready <= 1'b0;
            idle_cnt <= '0;
            err_nack <= 1'b0;
            err_udr <= 1'b0;
          end else begin
            idle_cnt <= idle_nxt;
            cmd_ready <= idle_nxt == IMIN;
          end
        end
        ST_HDR: begin
          mosi <= hdr[0];
          hdr <= hdr >> 1;
          cnt <= latch ? 3'd0 : cnt + 1'b1;
          if (latch) state <= ST_DATA;
        end
        ST_DATA: begin
          mosi <= tx_q[7];
          cnt <= cnt + 1'b1;
          if (cnt == 3'd7) begin
            state <= left == '0 ? ST_TAIL : ST_GAP;
            left <= left - 1'b1;
          end
        end
        ST_GAP: begin
          mosi <= 1'b0;
          state <= ST_DATA;
        end
        ST_TAIL: begin
          // first edge drops cs, second takes the held last miso bit and ends the frame
          cs <= 1'b0;
          mosi <= 1'b0;
          cnt <= cnt + 1'b1;
          if (cnt[0]) begin
            done <= 1'b1;
            state <= ST_IDLE;
            idle_cnt <= '0;
            cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: directed frames against a behavioural slave at ext 7
module tb_spi_frame_master;
  logic sclk = 0, rst = 1, cmd_valid = 0, cmd_wr = 0, wd_valid = 0, miso = 0, miso_oe = 0;
  logic [2:0] cmd_ext = 0, cmd_reg = 0, cmd_len = 0;
  logic [7:0] wd_data = 0, rd_data;
  logic cmd_ready, wd_ready, rd_valid, done, err_nack, err_udr, cs, mosi;
  always #5 sclk = ~sclk;
  spi_frame_master #(.LEN_W(3), .IDLE_MIN(1)) dut (
    .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_ext(cmd_ext), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .wd_valid(wd_valid),
    .wd_data(wd_data), .wd_ready(wd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err_nack(err_nack), .err_udr(err_udr), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe)
  );
  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int since = 0, cs_hi = 0, done_cnt = 0, done_at = -1, wd_cnt = 0, wd_idx = 0, wd_n = 0;
  bit cs_prev = 0;
  bit hb[64];
  logic [7:0] rd_q[$];
  logic [7:0] wd_list[4];
  always @(negedge sclk) begin
    if (cs && !cs_prev) since = 0;
    else since++;
    cs_prev = cs;
    if (cs) begin
      cs_hi++;
      if (since < 64) hb[since] = mosi;
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) begin
      done_cnt++;
      done_at = since;
    end
    if (wd_ready) begin
      wd_cnt++;
      wd_idx++;
      wd_valid = wd_idx < wd_n;
      wd_data = wd_list[wd_idx % 4];
    end
  end
  // slave model: observes outputs of edge A+n at the following negedge
  logic [7:0] mem[8];
  logic [7:0] shadow, rxb;
  logic [2:0] s_ext, s_reg, a;
  bit act = 0, s_wr;
  int n, b, r;
  always @(negedge sclk) begin
    if (cs || act) begin
      n = act ? n + 1 : 0;
      act = 1;
      if (n == 0) s_wr = mosi;
      else if (n <= 3) s_ext[n-1] = mosi;
      else if (n >= 5 && n <= 7) s_reg[n-5] = mosi;
      if (n == 7) miso_oe = s_ext == 3'd7;
      if (n >= 8) begin
        b = (n - 8) / 9;
        r = (n - 8) % 9;
        a = s_reg + 3'(b);
        if (r == 0) shadow = mem[a];
        if (r >= 1) miso = s_ext != 3'd7 ? 1'b1 : (s_wr ? shadow[8-r] : shadow[r-1]);
        if (r <= 7) rxb[7-r] = mosi;
        if (r == 7 && s_wr && s_ext == 3'd7) mem[a] = rxb;
      end
      if (!cs) act = 0;
    end else begin
      miso = 0;
      miso_oe = 0;
    end
  end
  function automatic logic [7:0] hbyte(input int s);
    logic [7:0] v = 0;
    for (int i = 0; i < 8; i++) v = {v[6:0], hb[s+i]};
    return v;
  endfunction
  function automatic logic [7:0] rd_at(input int i);
    return i < rd_q.size() ? rd_q[i] : 8'hxx;
  endfunction
  task automatic start(input logic wr, input logic [2:0] ext, input logic [2:0] rg, input logic [2:0] len);
    rd_q.delete();
    cs_hi = 0;
    done_cnt = 0;
    done_at = -1;
    wd_cnt = 0;
    wd_idx = 0;
    wd_valid = wd_n > 0;
    wd_data = wd_list[0];
    cmd_wr = wr;
    cmd_ext = ext;
    cmd_reg = rg;
    cmd_len = len;
    cmd_valid = 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge sclk);
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge sclk);
    cmd_valid = 0;
  endtask
  task automatic run(input logic wr, input logic [2:0] ext, input logic [2:0] rg, input logic [2:0] len);
    start(wr, ext, rg, len);
    for (int i = 0; i < 200 && !done; i++) @(negedge sclk);
    #1;
    check("done_count", done_cnt, 1);
  endtask
  initial begin
    mem = '{8'h12, 8'h00, 8'h35, 8'h00, 8'h5A, 8'h77, 8'h46, 8'h35};
    repeat (3) @(negedge sclk);
    check("rst_cs", cs, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_outs", {mosi, wd_ready, rd_valid, done, err_nack, err_udr}, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 0;
    @(negedge sclk);
    check("ready_after_rst", cmd_ready, 1);
    run(0, 7, 0, 0);
    check("rd1_count", rd_q.size(), 1);
    check("rd1_data", rd_at(0), 8'h12);
    check("rd1_done_at", done_at, 17);
    check("rd1_cs_high", cs_hi, 16);
    check("rd1_errs", {err_nack, err_udr}, 0);
    check("ready_at_done", cmd_ready, 0);
    @(negedge sclk);
    check("ready_idle_min", cmd_ready, 1);
    wd_list[0] = 8'hA5;
    wd_n = 1;
    run(1, 7, 2, 0);
    check("wr_hdr_mosi", hbyte(0), 8'hF2);
    check("wr_data_mosi", hbyte(8), 8'hA5);
    check("wr_old_data", rd_at(0), 8'h35);
    check("wr_slave_reg2", mem[2], 8'hA5);
    check("wr_wd_ready", wd_cnt, 1);
    check("wr_errs", {err_nack, err_udr}, 0);
    wd_n = 0;
    run(0, 7, 6, 2);
    check("burst_count", rd_q.size(), 3);
    check("burst_b0", rd_at(0), 8'h46);
    check("burst_b1", rd_at(1), 8'h35);
    check("burst_b2", rd_at(2), 8'h12);
    check("burst_cs_high", cs_hi, 34);
    check("burst_done_at", done_at, 35);
    run(0, 3, 1, 0);
    check("nack_data", rd_at(0), 8'h00);
    check("nack_err", err_nack, 1);
    check("nack_udr", err_udr, 0);
    wd_list[0] = 8'h3C;
    wd_n = 1;
    run(1, 7, 4, 1);
    check("udr_err", err_udr, 1);
    check("udr_nack", err_nack, 0);
    check("udr_wd_ready", wd_cnt, 1);
    check("udr_old0", rd_at(0), 8'h5A);
    check("udr_old1", rd_at(1), 8'h77);
    check("udr_mosi0", hbyte(8), 8'h3C);
    check("udr_mosi1", hbyte(17), 8'h00);
    check("udr_reg4", mem[4], 8'h3C);
    check("udr_reg5", mem[5], 8'h00);
    check("udr_cs_high", cs_hi, 25);
    wd_n = 0;
    start(0, 7, 0, 0);
    for (int i = 0; i < 40 && since != 12; i++) @(negedge sclk);
    check("abort_pos", since, 12);
    rst = 1;
    @(negedge sclk);
    check("abort_cs", cs, 0);
    rst = 0;
    repeat (30) @(negedge sclk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_no_rd", rd_q.size(), 0);
    run(0, 7, 0, 0);
    check("post_abort_rd", rd_at(0), 8'h12);
    check("post_abort_done_at", done_at, 17);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
